idli_sqi_rsp_m: RTL and testbench

SQI serial-SRAM responder, the memory-side end of the core's quad SPI memory interface. One instance sits behind the lo bus and one behind the hi bus in bench and FPGA builds. It decodes READ/WRITE commands, a 24-bit address and sequential nibble data. It is backed by a byte array and runs on the system clock, detecting SCK edges by sampling SCK.

---
 rtl/idli_sqi_rsp_m.sv | 175 +++++++++++++++++
 tb/tb_idli_sqi_rsp_m.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_rsp_m.sv
// SQI serial-SRAM responder: decodes READ (0x03) / WRITE (0x02), a 24-bit address and
// sequential nibble data against a byte array, detecting SCK edges on the system clock.
module idli_sqi_rsp_m #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic       i_rsp_gck,
  input  logic       i_rsp_rst_n,
  input  logic       i_rsp_sck,
  input  logic       i_rsp_cs,
  input  logic [3:0] i_rsp_sio,
  output logic [3:0] o_rsp_sio,
  output logic       o_rsp_sio_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StDummy,
    StRdData,
    StWrData,
    StIgnore
  } state_e;

  state_e              state_q, state_d;
  logic                sck_q;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cmd_hi_q, cmd_hi_d;
  logic                wr_q, wr_d;
  logic [3:0]          hold_q, hold_d;
  logic [3:0]          sio_q, sio_d;
  logic                oe_q, oe_d;

  logic [7:0]          mem [2**ADDR_W];
  logic                mem_we;
  logic [7:0]          mem_wdata;
  logic [7:0]          rd_byte;
  logic                rise, fall;

  assign rise    = i_rsp_sck & ~sck_q;
  assign fall    = ~i_rsp_sck & sck_q;
  assign rd_byte = mem[addr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cmd_hi_d  = cmd_hi_q;
    wr_d      = wr_q;
    hold_d    = hold_q;
    sio_d     = sio_q;
    oe_d      = oe_q;
    mem_we    = 1'b0;
    mem_wdata = {hold_q, i_rsp_sio};

    // Deselect wins over everything, including a coincident SCK rise.
    if (i_rsp_cs) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      sio_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            cmd_hi_d = i_rsp_sio;
            state_d  = StCmd;
          end
        end
        StCmd: begin
          if (rise) begin
            cnt_d = 3'd0;
            case ({cmd_hi_q, i_rsp_sio})
              8'h02: begin
                wr_d    = 1'b1;
                state_d = StAddr;
              end
              8'h03: begin
                wr_d    = 1'b0;
                state_d = StAddr;
              end
              default: state_d = StIgnore;
            endcase
          end
        end
        StAddr: begin
          if (rise) begin
            // Shifting into an ADDR_W register drops the unused upper address bits.
            addr_d = {addr_q[ADDR_W-5:0], i_rsp_sio};
            if (cnt_q == 3'd5) begin
              cnt_d   = 3'd0;
              state_d = wr_q ? StWrData : StDummy;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        StDummy: begin
          if (rise) begin
            if (cnt_q == 3'd1) begin
              cnt_d   = 3'd0;
              state_d = StRdData;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        StRdData: begin
          if (fall) begin
            oe_d = 1'b1;
            if (cnt_q[0]) begin
              sio_d  = rd_byte[3:0];
              addr_d = addr_q + ADDR_W'(1);
              cnt_d  = 3'd0;
            end else begin
              sio_d = rd_byte[7:4];
              cnt_d = 3'd1;
            end
          end
        end
        StWrData: begin
          if (rise) begin
            if (cnt_q[0]) begin
              mem_we = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              cnt_d  = 3'd0;
            end else begin
              hold_d = i_rsp_sio;
              cnt_d  = 3'd1;
            end
          end
        end
        StIgnore: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_rsp_gck or negedge i_rsp_rst_n) begin
    if (!i_rsp_rst_n) begin
      state_q  <= StIdle;
      sck_q    <= 1'b0;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      cmd_hi_q <= 4'd0;
      wr_q     <= 1'b0;
      hold_q   <= 4'd0;
      sio_q    <= 4'd0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sck_q    <= i_rsp_sck;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      cmd_hi_q <= cmd_hi_d;
      wr_q     <= wr_d;
      hold_q   <= hold_d;
      sio_q    <= sio_d;
      oe_q     <= oe_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge i_rsp_gck) begin
    if (mem_we) begin
      mem[addr_q] <= mem_wdata;
    end
  end

  assign o_rsp_sio    = sio_q;
  assign o_rsp_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_rsp_m.sv
// Directed bench for idli_sqi_rsp_m: a byte-array model predicts the driven nibbles, a compare
// process checks the outputs every cycle, and read-back bytes are pinned to literal values.
module tb_idli_sqi_rsp_m;

  localparam int unsigned AddrW = 17;
  localparam int MASK = (1 << AddrW) - 1;

  logic       gck;
  logic       rst_n;
  logic       sck;
  logic       cs;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       sio_oe;

  int errors;
  int checks;

  logic       exp_oe;
  logic [3:0] exp_sio;
  logic [3:0] last_sio;
  logic [7:0] mdl [int];
  logic [7:0] got [4];

  idli_sqi_rsp_m #(.ADDR_W(AddrW)) dut (
    .i_rsp_gck   (gck),
    .i_rsp_rst_n (rst_n),
    .i_rsp_sck   (sck),
    .i_rsp_cs    (cs),
    .i_rsp_sio   (sio_in),
    .o_rsp_sio   (sio_out),
    .o_rsp_sio_oe(sio_oe)
  );

  initial gck = 1'b0;
  always #5 gck = ~gck;

  // Per-cycle comparison against the model's expected output state.
  always begin
    @(posedge gck);
    #2;
    checks++;
    if (sio_oe !== exp_oe || sio_out !== exp_sio) begin
      errors++;
      $display("FAIL cycle_out t=%0t: oe=%b sio=%h, required oe=%b sio=%h",
               $time, sio_oe, sio_out, exp_oe, exp_sio);
    end
  end

  function automatic logic [7:0] mdl_rd(input int a);
    int k;
    k = a & MASK;
    if (mdl.exists(k)) return mdl[k];
    return 8'h00;
  endfunction

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One SCK period: rise carries nib; optionally the fall makes the responder drive dval.
  task automatic pulse(input logic [3:0] nib, input bit drv, input logic [3:0] dval);
    @(negedge gck);
    sck = 1'b1;
    sio_in = nib;
    @(negedge gck);
    @(negedge gck);
    sck = 1'b0;
    if (drv) begin
      exp_oe  = 1'b1;
      exp_sio = dval;
    end
    @(posedge gck);
    #2;
    last_sio = sio_out;
    @(negedge gck);
  endtask

  task automatic deselect();
    @(negedge gck);
    cs      = 1'b1;
    exp_oe  = 1'b0;
    exp_sio = 4'h0;
    repeat (3) @(negedge gck);
  endtask

  task automatic header(input logic [7:0] cmd, input logic [23:0] addr);
    @(negedge gck);
    cs = 1'b0;
    pulse(cmd[7:4], 1'b0, 4'h0);
    pulse(cmd[3:0], 1'b0, 4'h0);
    for (int i = 5; i >= 0; i--) pulse(addr[i*4 +: 4], 1'b0, 4'h0);
  endtask

  task automatic write_tx(input logic [23:0] addr, input int n, input logic [7:0] d [4],
                          input int part_nib);
    header(8'h02, addr);
    for (int i = 0; i < n; i++) begin
      pulse(d[i][7:4], 1'b0, 4'h0);
      pulse(d[i][3:0], 1'b0, 4'h0);
      mdl[(int'(addr) + i) & MASK] = d[i];
    end
    if (part_nib >= 0) pulse(4'(part_nib), 1'b0, 4'h0);
    deselect();
  endtask

  // Reads n bytes; if rst_after >= 0, asserts reset after that data nibble is driven.
  task automatic read_tx(input logic [23:0] addr, input int n, input int rst_after);
    logic [7:0] b;
    logic [3:0] nib;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    header(8'h03, addr);
    pulse(4'hF, 1'b0, 4'h0);
    for (int k = 0; k < 2 * n; k++) begin
      b   = mdl_rd(int'(addr) + k / 2);
      nib = (k % 2 == 0) ? b[7:4] : b[3:0];
      pulse(4'(k), 1'b1, nib);
      if (k % 2 == 0) got[k/2][7:4] = last_sio;
      else got[k/2][3:0] = last_sio;
      if (k == rst_after) begin
        @(negedge gck);
        rst_n   = 1'b0;
        exp_oe  = 1'b0;
        exp_sio = 4'h0;
        #1;
        checks++;
        if (sio_oe !== 1'b0 || sio_out !== 4'h0) begin
          errors++;
          $display("FAIL async_reset: oe=%b sio=%h, required oe=0 sio=0", sio_oe, sio_out);
        end
        repeat (3) @(negedge gck);
        cs = 1'b1;
        @(negedge gck);
        rst_n = 1'b1;
        repeat (2) @(negedge gck);
        return;
      end
    end
    repeat (3) @(negedge gck);
    deselect();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    sck     = 1'b0;
    cs      = 1'b1;
    sio_in  = 4'h0;
    exp_oe  = 1'b0;
    exp_sio = 4'h0;
    repeat (3) @(negedge gck);
    checks++;
    if (sio_oe !== 1'b0 || sio_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: oe=%b sio=%h, required oe=0 sio=0", sio_oe, sio_out);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge gck);

    // Basic write then sequential read.
    write_tx(24'h000010, 2, '{8'hA5, 8'h3C, 8'h00, 8'h00}, -1);
    read_tx(24'h000010, 2, -1);
    check8("rd_10", got[0], 8'hA5);
    check8("rd_11", got[1], 8'h3C);

    // Address wrap at the top of the array.
    write_tx(24'h01FFFF, 2, '{8'h11, 8'h22, 8'h00, 8'h00}, -1);
    read_tx(24'h000000, 1, -1);
    check8("wrap_rd_0", got[0], 8'h22);
    read_tx(24'h01FFFF, 1, -1);
    check8("wrap_rd_1ffff", got[0], 8'h11);
    read_tx(24'h01FFFF, 2, -1);
    check8("wrap_seq_0", got[0], 8'h11);
    check8("wrap_seq_1", got[1], 8'h22);

    // Upper address bits dropped.
    write_tx(24'hFE0004, 1, '{8'h7E, 8'h00, 8'h00, 8'h00}, -1);
    read_tx(24'h000004, 1, -1);
    check8("upper_bits", got[0], 8'h7E);

    // Unsupported command: responder stays silent, array untouched.
    @(negedge gck);
    cs = 1'b0;
    pulse(4'h0, 1'b0, 4'h0);
    pulse(4'h5, 1'b0, 4'h0);
    for (int i = 0; i < 8; i++) pulse(4'((i * 7 + 3) & 15), 1'b0, 4'h0);
    deselect();
    read_tx(24'h000010, 1, -1);
    check8("after_ignore", got[0], 8'hA5);

    // Partial write byte discarded.
    write_tx(24'h000021, 1, '{8'h5A, 8'h00, 8'h00, 8'h00}, -1);
    write_tx(24'h000020, 1, '{8'h96, 8'h00, 8'h00, 8'h00}, 15);
    read_tx(24'h000020, 2, -1);
    check8("partial_20", got[0], 8'h96);
    check8("partial_21", got[1], 8'h5A);

    // Reset during the second data nibble, then a fresh read.
    read_tx(24'h000010, 2, 1);
    check8("pre_rst_hi", got[0][7:4], 8'h0A);
    read_tx(24'h000010, 2, -1);
    check8("post_rst_10", got[0], 8'hA5);
    check8("post_rst_11", got[1], 8'h3C);

    repeat (4) @(negedge gck);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
